// File: rtl/mem_lsu.sv
// Load/store unit in front of a single-port synchronous data RAM.
// Turns byte-addressed RV32I loads/stores into word accesses, with read-modify-write for sub-word stores.
module mem_lsu #(
   parameter int RAM_ADDR_W = 10
) (
   input  logic                  CLK,
   input  logic                  RESET,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [2:0]            req_funct3,
   input  logic [31:0]           req_addr,
   input  logic [31:0]           req_wdata,
   output logic                  resp_valid,
   output logic [31:0]           resp_rdata,
   output logic                  resp_err,
   output logic [RAM_ADDR_W-1:0] ram_address,
   output logic [31:0]           ram_data,
   output logic                  ram_wren,
   input  logic [31:0]           ram_salida
);

   typedef enum logic [2:0] {IDLE, ACCESS, WAIT, WRITE, RESP} state_t;

   state_t      state_reg;
   logic [1:0]  lane_reg;
   logic [2:0]  funct3_reg;
   logic        we_reg;
   logic [15:0] wdata_reg;

   logic        req_err;
   logic [7:0]  byte_lane [4];
   logic [15:0] half_lane [2];
   logic [7:0]  sel_byte;
   logic [15:0] sel_half;
   logic [31:0] load_data;
   logic [31:0] merged_b;
   logic [31:0] merged_h;

   assign req_ready = (state_reg == IDLE);

   always_comb begin
      req_err = 1'b0;
      case (req_funct3)
         3'b000, 3'b100: req_err = 1'b0;
         3'b001, 3'b101: req_err = req_addr[0];
         3'b010:         req_err = |req_addr[1:0];
         default:        req_err = 1'b1;
      endcase
      // BU/HU have no store counterpart
      if (req_we && req_funct3[2])
         req_err = 1'b1;
      if (|req_addr[31:RAM_ADDR_W+2])
         req_err = 1'b1;
   end

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_byte
         assign byte_lane[gi] = ram_salida[8*gi +: 8];
         assign merged_b[8*gi +: 8] = (lane_reg == 2'(gi)) ? wdata_reg[7:0] : ram_salida[8*gi +: 8];
      end
      for (gi = 0; gi < 2; gi++) begin : g_half
         assign half_lane[gi] = ram_salida[16*gi +: 16];
         assign merged_h[16*gi +: 16] = (lane_reg[1] == 1'(gi)) ? wdata_reg : ram_salida[16*gi +: 16];
      end
   endgenerate

   assign sel_byte = byte_lane[lane_reg];
   assign sel_half = half_lane[lane_reg[1]];

   always_comb begin
      load_data = ram_salida;
      case (funct3_reg)
         3'b000:  load_data = {{24{sel_byte[7]}}, sel_byte};
         3'b001:  load_data = {{16{sel_half[15]}}, sel_half};
         3'b100:  load_data = {24'd0, sel_byte};
         3'b101:  load_data = {16'd0, sel_half};
         default: load_data = ram_salida;
      endcase
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_reg   <= IDLE;
         lane_reg    <= 2'd0;
         funct3_reg  <= 3'd0;
         we_reg      <= 1'b0;
         wdata_reg   <= 16'd0;
         ram_address <= '0;
         ram_data    <= 32'd0;
         ram_wren    <= 1'b0;
         resp_valid  <= 1'b0;
         resp_rdata  <= 32'd0;
         resp_err    <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (req_valid) begin
                  lane_reg   <= req_addr[1:0];
                  funct3_reg <= req_funct3;
                  we_reg     <= req_we;
                  wdata_reg  <= req_wdata[15:0];
                  if (req_err) begin
                     resp_err   <= 1'b1;
                     resp_valid <= 1'b1;
                     state_reg  <= RESP;
                  end else begin
                     resp_err    <= 1'b0;
                     ram_address <= req_addr[RAM_ADDR_W+1:2];
                     // Full words skip the read and write straight away
                     if (req_we && req_funct3 == 3'b010) begin
                        ram_data <= req_wdata;
                        ram_wren <= 1'b1;
                     end
                     state_reg <= ACCESS;
                  end
               end
            end
            ACCESS: begin
               ram_wren <= 1'b0;
               if (we_reg && funct3_reg == 3'b010) begin
                  resp_valid <= 1'b1;
                  state_reg  <= RESP;
               end else begin
                  state_reg <= WAIT;
               end
            end
            WAIT: begin
               if (we_reg) begin
                  ram_data  <= (funct3_reg[1:0] == 2'b00) ? merged_b : merged_h;
                  ram_wren  <= 1'b1;
                  state_reg <= WRITE;
               end else begin
                  resp_rdata <= load_data;
                  resp_valid <= 1'b1;
                  state_reg  <= RESP;
               end
            end
            WRITE: begin
               ram_wren   <= 1'b0;
               resp_valid <= 1'b1;
               state_reg  <= RESP;
            end
            RESP: begin
               resp_valid <= 1'b0;
               state_reg  <= IDLE;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/mem_lsu.md
Name: mem_lsu

Overview:
- Load/store unit sitting directly upstream of the data RAM (1024 x 32, synchronous, one-cycle read latency, ports data/clock/wren/address/salida).
- Accepts byte-addressed RV32I-style load/store requests from the core and translates them into word-addressed RAM accesses.
- Performs read-modify-write for byte/halfword stores and sign/zero extension for loads.
- One request outstanding at a time, valid/ready handshake on the request side, single-cycle response pulse.

Parameters:
RAM_ADDR_W, 10, RAM word-address width; the addressable space is 4*2^RAM_ADDR_W bytes.

Ports:
CLK  in  1  system clock, all state updates on rising edge
RESET  in  1  asynchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  unit idle and able to accept; high only in IDLE
req_we  in  1  1 = store, 0 = load
req_funct3  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU are loads only)
req_addr  in  32  byte address
req_wdata  in  32  store data; the low byte/half is used for B/H
resp_valid  out  1  one-cycle response pulse
resp_rdata  out  32  load result, held until the next response
resp_err  out  1  qualified by resp_valid: misaligned, illegal funct3 or out of range
ram_address  out  RAM_ADDR_W  word address to RAM
ram_data  out  32  write data to RAM
ram_wren  out  1  RAM write enable
ram_salida  in  32  RAM read data, valid the cycle after the address is sampled

Behaviour:
- Reset (async, RESET=1):
  - state=IDLE.
  - ram_wren=0, ram_address=0, ram_data=0.
  - resp_valid=0, resp_rdata=0, resp_err=0.
  - req_ready=1 once RESET deasserts.
- Reset mid-operation aborts immediately. ram_wren drops without waiting for a clock edge, and no response is produced. A sub-word RMW interrupted before WRITE leaves the RAM unchanged.
- Accept happens when req_valid && req_ready at a rising edge. At that edge the unit latches addr, funct3, we and wdata.
- States: IDLE, ACCESS, WAIT, WRITE, RESP. All outputs are registered except req_ready, which is decoded from state.
- Error check at accept. Any of the following is an error:
  - B/H/W with funct3 not in {000,001,010,100,101}, or a store with funct3 in {100,101}.
  - Halfword with addr[0]=1.
  - Word with addr[1:0]!=0.
  - addr[31:RAM_ADDR_W+2] != 0.
  On error: IDLE -> RESP, ram_wren stays 0, resp_err=1, and resp_rdata is unchanged.
- Word store (SW): at accept the unit registers ram_address=addr[RAM_ADDR_W+1:2], ram_data=wdata and ram_wren=1, then goes to ACCESS. At the next edge the RAM writes, ram_wren<=0 and the unit goes to RESP.
- Load, or byte/halfword store: at accept the unit registers ram_address with ram_wren=0 and goes to ACCESS. After one edge it goes to WAIT, where ram_salida is valid.
- From WAIT:
  - Load: register resp_rdata = extracted lane, extended as below, then go to RESP.
  - Sub-word store: register ram_data = ram_salida with the target lane replaced by wdata[7:0] or wdata[15:0], set ram_wren=1 and go to WRITE. From WRITE go to RESP with ram_wren<=0.
- Lane order is little-endian:
  - Byte k = bits [8k+7:8k], with k = addr[1:0].
  - Halfword at addr[1]=0 is bits [15:0], at addr[1]=1 bits [31:16].
- Extension:
  - B and H are sign-extended from bit 7 and bit 15.
  - BU and HU are zero-extended.
  - W passes through.
- RESP: resp_valid=1 for exactly one cycle, then IDLE. req_ready=0 in every state except IDLE, so back-to-back requests see one idle cycle each.
- Latency, counting the accept cycle as 0, gives resp_valid high in:
  - Error: cycle 1.
  - SW: cycle 2.
  - Load: cycle 3.
  - SB/SH: cycle 4.
- ram_wren is high for exactly one cycle per successful store and never for loads or errors.
- req_valid and the request fields may change freely while req_ready=0; the unit ignores them.

Test Plan:
1. SW addr=0x004, wdata=43, then LW addr=0x004 -> exactly one ram_wren pulse with ram_address=1, ram_data=43. The load gives resp_rdata=43 in cycle 3, resp_err=0.
2. SW addr=0x080, wdata=0x11223344, then SB addr=0x082, wdata=0xAB, then LW 0x080 -> resp_rdata=0x11AB3344. The SB response comes in cycle 4.
3. With word 0x80FF7F01 at addr 0x010:
   - LB 0x010 -> 0x00000001.
   - LB 0x013 -> 0xFFFFFF80.
   - LBU 0x013 -> 0x00000080.
   - LH 0x012 -> 0xFFFF80FF.
   - LHU 0x012 -> 0x000080FF.
4. Errors: LW 0x006, SH 0x001, funct3=011, and addr=0x1000 -> each gives resp_valid with resp_err=1 in cycle 1. ram_wren never rises, and RAM contents are unchanged on readback.
5. Assert RESET in the WAIT state of an SH to 0x020 whose word was 0x12345678 -> ram_wren stays 0 and no resp_valid appears. After release, req_ready=1, and LW 0x020 reads back 0x12345678.
6. Hold req_valid=1 continuously over 4 loads -> each accepted only in IDLE, 4 resp_valid pulses, no request dropped or duplicated.
